// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: queues data_io download bytes and writes them to the
// two SDRAM toggle-handshake ports, then raises rom_loaded / core_reset.
module rom_dl_sequencer #(
    parameter logic [24:0] CPU_BASE   = 25'h00C000,
    parameter logic [24:0] CPU_SIZE   = 25'h010000,
    parameter logic [24:0] BG_BASE    = 25'h006000,
    parameter logic [24:0] BG_SIZE    = 25'h006000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          ACK_TOUT   = 1023
) (
    input  logic        clk_sys,
    input  logic        RESETn,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ext_reset,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic [1:0]  dl_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TOUT = TW'(ACK_TOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state_q;
    logic          wr_q, dl_q;
    logic          cap_vld_q;
    logic [24:0]   cap_addr_q;
    logic [7:0]    cap_dat_q;
    logic [24:0]   mem_addr [FIFO_DEPTH];
    logic [7:0]    mem_dat  [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q, tout_q;
    logic          tgt_q;
    logic [TW-1:0] tmr_q;
    logic          pend_q, loaded_q, crst_q;
    logic          p1_req_q, p2_req_q;
    logic [22:0]   p1_a_q, p2_a_q;
    logic [1:0]    p1_ds_q, p2_ds_q;
    logic [15:0]   p1_d_q, p2_d_q;

    logic          strobe, dl_rise, dl_fall;
    logic          pop, full, push, drop;
    logic [24:0]   head_addr, off1, off2;
    logic [7:0]    head_dat;
    logic          hit1, hit2;
    logic          cur_req, cur_ack, idle_empty;
    logic          unused_bits;

    assign strobe  = ioctl_wr & ~wr_q & ioctl_downl;
    assign dl_rise = ioctl_downl & ~dl_q;
    assign dl_fall = ~ioctl_downl & dl_q;

    assign pop  = (state_q == S_IDLE) && (cnt_q != '0);
    assign full = (cnt_q == FULL);
    assign push = cap_vld_q && (!full || pop);
    assign drop = cap_vld_q && full && !pop;

    assign head_addr = mem_addr[rp_q];
    assign head_dat  = mem_dat[rp_q];
    assign off1 = head_addr - CPU_BASE;
    assign off2 = head_addr - BG_BASE;
    assign hit1 = off1 < CPU_SIZE;
    assign hit2 = off2 < BG_SIZE;
    assign unused_bits = ^{off1[24], off2[24:21]};

    assign cur_req = tgt_q ? p2_req_q : p1_req_q;
    assign cur_ack = tgt_q ? port2_ack : port1_ack;
    assign idle_empty = (state_q == S_IDLE) && (cnt_q == '0) && !cap_vld_q;

    assign port1_req  = p1_req_q;
    assign port1_a    = p1_a_q;
    assign port1_ds   = p1_ds_q;
    assign port1_d    = p1_d_q;
    assign port2_req  = p2_req_q;
    assign port2_a    = p2_a_q;
    assign port2_ds   = p2_ds_q;
    assign port2_d    = p2_d_q;
    assign port_we    = ioctl_downl;
    assign rom_loaded = loaded_q;
    assign core_reset = crst_q;
    assign dl_err     = {tout_q, ovf_q};

    // Detect new byte strobes and latch the byte for one-cycle-later push
    always_ff @(posedge clk_sys or negedge RESETn) begin
        if (!RESETn) begin
            wr_q       <= 1'b0;
            dl_q       <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
            cap_dat_q  <= '0;
        end else begin
            wr_q      <= ioctl_wr;
            dl_q      <= ioctl_downl;
            cap_vld_q <= strobe;
            if (strobe) begin
                cap_addr_q <= ioctl_addr;
                cap_dat_q  <= ioctl_dout;
            end
        end
    end

    // FIFO storage, no reset needed: entries are only read when counted
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_addr[wp_q] <= cap_addr_q;
            mem_dat[wp_q]  <= cap_dat_q;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk_sys or negedge RESETn) begin
        if (!RESETn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (dl_rise)   ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    // Write sequencer, ack timeout and download-completion tracking
    always_ff @(posedge clk_sys or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_IDLE;
            tgt_q    <= 1'b0;
            tmr_q    <= '0;
            tout_q   <= 1'b0;
            p1_req_q <= 1'b0;
            p1_a_q   <= '0;
            p1_ds_q  <= '0;
            p1_d_q   <= '0;
            p2_req_q <= 1'b0;
            p2_a_q   <= '0;
            p2_ds_q  <= '0;
            p2_d_q   <= '0;
            pend_q   <= 1'b0;
            loaded_q <= 1'b0;
            crst_q   <= 1'b1;
        end else begin
            if (dl_rise) tout_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop && hit1) begin
                        p1_a_q  <= off1[23:1];
                        p1_ds_q <= {off1[0], ~off1[0]};
                        p1_d_q  <= {head_dat, head_dat};
                        tgt_q   <= 1'b0;
                        state_q <= S_ISSUE;
                    end else if (pop && hit2) begin
                        p2_a_q  <= {3'b000, off2[20:15],
                                    off2[12:0], off2[14]};
                        p2_ds_q <= {off2[13], ~off2[13]};
                        p2_d_q  <= {head_dat, head_dat};
                        tgt_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cur_req == cur_ack) begin
                        if (tgt_q) p2_req_q <= ~p2_req_q;
                        else       p1_req_q <= ~p1_req_q;
                        tmr_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cur_req == cur_ack) begin
                        state_q <= S_IDLE;
                    end else if (tmr_q == TOUT) begin
                        tout_q <= 1'b1;
                        if (tgt_q) p2_req_q <= port2_ack;
                        else       p1_req_q <= port1_ack;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (dl_rise) begin
                pend_q <= 1'b0;
            end else if (dl_fall) begin
                pend_q <= 1'b1;
            end else if (pend_q && idle_empty) begin
                loaded_q <= 1'b1;
                pend_q   <= 1'b0;
            end
            crst_q <= ext_reset | ~loaded_q | ioctl_downl;
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: directed vectors against rom_dl_sequencer with a
// toggle-ack SDRAM responder and a log of issued writes.
module tb_rom_dl_sequencer;

    logic        clk_sys = 1'b0;
    logic        RESETn = 1'b0;
    logic        ioctl_downl = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ext_reset = 1'b0;
    logic        port1_req, port2_req;
    logic        port1_ack = 1'b0;
    logic        port2_ack = 1'b0;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        port_we, rom_loaded, core_reset;
    logic [1:0]  dl_err;

    rom_dl_sequencer dut (
        .clk_sys(clk_sys), .RESETn(RESETn),
        .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ext_reset(ext_reset),
        .port1_req(port1_req), .port1_ack(port1_ack),
        .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack),
        .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
        .port_we(port_we), .rom_loaded(rom_loaded),
        .core_reset(core_reset), .dl_err(dl_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        port;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } wr_t;

    wr_t  wr_log[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   dly1 = 5;
    int   dly2 = 5;
    bit   en1 = 1'b1;
    bit   en2 = 1'b1;
    int   c1 = 0;
    int   c2 = 0;
    int   n_ack1 = 0;
    int   n_ack2 = 0;
    logic p1_prev = 1'b0;
    logic p2_prev = 1'b0;

    // SDRAM responder plus write monitor (logs new requests only)
    always @(negedge clk_sys) begin
        if (!RESETn) begin
            port1_ack = 1'b0;
            port2_ack = 1'b0;
            p1_prev = 1'b0;
            p2_prev = 1'b0;
            c1 = 0;
            c2 = 0;
        end else begin
            if (port1_req != p1_prev) begin
                if (port1_req != port1_ack)
                    wr_log.push_back('{1'b0, port1_a, port1_ds, port1_d});
                p1_prev = port1_req;
            end
            if (port2_req != p2_prev) begin
                if (port2_req != port2_ack)
                    wr_log.push_back('{1'b1, port2_a, port2_ds, port2_d});
                p2_prev = port2_req;
            end
            if (port1_req != port1_ack && en1) begin
                c1++;
                if (c1 >= dly1) begin
                    port1_ack = port1_req;
                    c1 = 0;
                    n_ack1++;
                end
            end else if (port1_req == port1_ack) begin
                c1 = 0;
            end
            if (port2_req != port2_ack && en2) begin
                c2++;
                if (c2 >= dly2) begin
                    port2_ack = port2_req;
                    c2 = 0;
                    n_ack2++;
                end
            end else if (port2_req == port2_ack) begin
                c2 = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
    endtask

    task automatic wait_n(input int n, input int lim, input string tag);
        for (int i = 0; i < lim && wr_log.size() < n; i++) tick();
        chk(tag, wr_log.size(), n);
    endtask

    task automatic expect_wr(input string tag, input logic port,
                             input logic [22:0] a, input logic [1:0] ds,
                             input logic [15:0] d);
        wr_t w;
        if (wr_log.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
        end else begin
            w = wr_log.pop_front();
            chk({tag, "_port"}, w.port, port);
            chk({tag, "_a"}, w.a, a);
            chk({tag, "_ds"}, w.ds, ds);
            chk({tag, "_d"}, w.d, d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k, base, ack_t, ld_t;
        idle(3);
        chk("rst_p1req", port1_req, 0);
        chk("rst_p2req", port2_req, 0);
        chk("rst_p1a", port1_a, 0);
        chk("rst_p1ds", port1_ds, 0);
        chk("rst_p1d", port1_d, 0);
        chk("rst_p2a", port2_a, 0);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_creset", core_reset, 1);
        chk("rst_err", dl_err, 0);
        RESETn = 1'b1;
        tick();
        ioctl_downl = 1'b1;
        tick();
        chk("we", port_we, 1);
        chk("creset_dl", core_reset, 1);

        // first byte: latency and CPU mapping
        ioctl_addr = 25'h00C001;
        ioctl_dout = 8'hA5;
        ioctl_wr = 1'b1;
        lat = 0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 1) ioctl_wr = 1'b0;
            if (port1_req && lat == 0) lat = j;
        end
        chk("latency", lat, 4);
        wait_n(1, 20, "cpu1_cnt");
        expect_wr("cpu1", 1'b0, 23'h0, 2'b10, 16'hA5A5);
        idle(10);
        chk("cpu1_p1req", port1_req, 1);
        chk("cpu1_p2req", port2_req, 0);
        chk("cpu1_acks", n_ack1, 1);

        // BG mapping, bit shuffle, port1 untouched
        strobe(25'h00A003, 8'h3C);
        wait_n(1, 30, "bg1_cnt");
        expect_wr("bg1", 1'b1, 23'h7, 2'b01, 16'h3C3C);
        idle(10);
        chk("bg1_p1req", port1_req, 1);
        strobe(25'h008005, 8'h11);
        wait_n(1, 30, "bg2_cnt");
        expect_wr("bg2", 1'b1, 23'hA, 2'b10, 16'h1111);
        idle(10);

        // region end boundaries
        strobe(25'h01BFFF, 8'h77);
        wait_n(1, 30, "cpuend_cnt");
        expect_wr("cpuend", 1'b0, 23'h7FFF, 2'b10, 16'h7777);
        idle(10);
        strobe(25'h00BFFF, 8'h88);
        wait_n(1, 30, "bgend_cnt");
        expect_wr("bgend", 1'b1, 23'h3FFF, 2'b01, 16'h8888);
        idle(10);

        // unmapped addresses: discarded without any request
        strobe(25'h001000, 8'h01);
        strobe(25'h01C000, 8'h02);
        strobe(25'h005FFF, 8'h03);
        idle(20);
        chk("disc_cnt", wr_log.size(), 0);
        chk("disc_err", dl_err, 0);
        chk("disc_p1", port1_req, port1_ack);
        chk("disc_p2", port2_req, port2_ack);

        // overflow: one byte in flight, four buffered, sixth dropped
        dly1 = 40;
        for (int i = 0; i < 6; i++)
            strobe(25'h00C010 + 25'(i), 8'h50 + 8'(i));
        wait_n(5, 400, "ovf_cnt");
        idle(60);
        chk("ovf_no6th", wr_log.size(), 5);
        for (int i = 0; i < 5; i++)
            expect_wr($sformatf("ovf%0d", i), 1'b0, 23'((16 + i) >> 1),
                      (i % 2 == 1) ? 2'b10 : 2'b01,
                      {2{8'h50 + 8'(i)}});
        chk("ovf_err", dl_err, 2'b01);

        // ack timeout then normal recovery
        dly1 = 5;
        en1 = 1'b0;
        strobe(25'h00C020, 8'h99);
        wait_n(1, 20, "to_issue");
        k = 0;
        while (k < 1200 && !dl_err[1]) begin
            tick();
            k++;
        end
        chk("to_cycles", k, 1024);
        chk("to_err", dl_err, 2'b11);
        chk("to_resync", port1_req, port1_ack);
        expect_wr("to_wr", 1'b0, 23'h10, 2'b01, 16'h9999);
        en1 = 1'b1;
        strobe(25'h00C021, 8'h9A);
        wait_n(1, 30, "rec_cnt");
        expect_wr("rec", 1'b0, 23'h10, 2'b10, 16'h9A9A);
        idle(10);
        chk("rec_match", port1_req, port1_ack);

        // completion with three bytes still queued
        base = n_ack1;
        strobe(25'h00C040, 8'hC0);
        strobe(25'h00C041, 8'hC1);
        strobe(25'h00C042, 8'hC2);
        ioctl_downl = 1'b0;
        ack_t = -1;
        ld_t = -1;
        for (int i = 0; i < 300 && ld_t < 0; i++) begin
            if (ack_t < 0 && n_ack1 - base == 3) ack_t = i;
            if (rom_loaded) ld_t = i;
            else tick();
        end
        chk("done_acks", n_ack1 - base, 3);
        chk("done_delay", ld_t - ack_t, 2);
        chk("done_creset_hi", core_reset, 1);
        tick();
        chk("done_creset_lo", core_reset, 0);
        chk("done_wrs", wr_log.size(), 3);
        wr_log.delete();

        // strobes without download are ignored
        strobe(25'h00C050, 8'h01);
        idle(20);
        chk("nodl_cnt", wr_log.size(), 0);
        chk("err_sticky", dl_err, 2'b11);

        // new download: errors clear, rom_loaded sticky
        ioctl_downl = 1'b1;
        idle(2);
        chk("redl_err", dl_err, 0);
        chk("redl_loaded", rom_loaded, 1);
        chk("redl_creset", core_reset, 1);
        ioctl_downl = 1'b0;
        idle(2);
        chk("ext_lo", core_reset, 0);
        ext_reset = 1'b1;
        idle(2);
        chk("ext_hi", core_reset, 1);
        ext_reset = 1'b0;
        idle(2);
        chk("ext_rel", core_reset, 0);

        // async reset while waiting for ack
        ioctl_downl = 1'b1;
        if (port1_req) begin
            strobe(25'h00C060, 8'h40);
            idle(20);
        end
        wr_log.delete();
        en1 = 1'b0;
        strobe(25'h00C061, 8'h42);
        wait_n(1, 20, "ar_issue");
        chk("ar_pre", port1_req, 1);
        #2;
        RESETn = 1'b0;
        #1;
        chk("ar_req", port1_req, 0);
        chk("ar_loaded", rom_loaded, 0);
        chk("ar_creset", core_reset, 1);
        idle(3);
        RESETn = 1'b1;
        en1 = 1'b1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
